// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32I core: sequences the shared datapath
// through fetch/decode/execute/memory/writeback and drives every enable and select.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       lt,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [2:0] alu_ctrl,
    output logic       reg_write,
    output logic       instr_done,
    output logic [3:0] state
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXEC_R   = 4'd6;
    localparam logic [3:0] ALUWB    = 4'd7;
    localparam logic [3:0] EXEC_I   = 4'd8;
    localparam logic [3:0] JAL      = 4'd9;
    localparam logic [3:0] BRANCH   = 4'd10;
    localparam logic [3:0] JALR     = 4'd11;
    localparam logic [3:0] LUI      = 4'd12;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    logic [3:0] state_q, state_d;
    logic [2:0] func_ctrl;
    logic       taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXEC_R;
                    OP_I:         state_d = EXEC_I;
                    OP_JAL:       state_d = JAL;
                    OP_BR:        state_d = BRANCH;
                    OP_JALR:      state_d = JALR;
                    OP_LUI:       state_d = LUI;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD: state_d = MEMWB;
            EXEC_R, EXEC_I, LUI, JAL: state_d = (state_q == JAL || state_q != JAL) ? ALUWB : FETCH;
            JALR:    state_d = JAL;
            default: state_d = FETCH;
        endcase
    end

    // sub only for register-register with instr[30] set; shifts fall back to add
    always_comb begin
        func_ctrl = 3'b000;
        case (funct3)
            3'b000:  func_ctrl = (op == OP_R && funct7b5) ? 3'b001 : 3'b000;
            3'b010:  func_ctrl = 3'b101;
            3'b011:  func_ctrl = 3'b110;
            3'b100:  func_ctrl = 3'b100;
            3'b110:  func_ctrl = 3'b011;
            3'b111:  func_ctrl = 3'b010;
            default: func_ctrl = 3'b000;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        imm_src    = 3'b000;
        alu_ctrl   = 3'b000;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_write   = 1'b1;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = (op == OP_JAL) ? 3'b011 : 3'b010;
                case (op)
                    OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BR, OP_JALR, OP_LUI: instr_done = 1'b0;
                    default: instr_done = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = (op == OP_SW) ? 3'b001 : 3'b000;
            end
            MEMREAD: adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = 1'b1;
            end
            EXEC_R: begin
                alu_src_a = 2'b10;
                alu_ctrl  = func_ctrl;
            end
            EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_ctrl  = func_ctrl;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            // PC takes the target from ALUOut while the ALU forms the link value
            JAL: begin
                pc_write  = 1'b1;
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            BRANCH: begin
                alu_src_a  = 2'b10;
                alu_ctrl   = 3'b001;
                instr_done = 1'b1;
                pc_write   = taken;
            end
            JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                imm_src   = 3'b100;
            end
            default: ;
        endcase
    end

endmodule
